// File: rtl/out_bcd_converter_pkg.sv
// Shared constants for the output-path binary-to-BCD converter.
package out_bcd_converter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Pre-shift correction for one BCD digit; inputs 5..9 map to 8..12, never overflowing 4 bits.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] d);
        return (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;
    endfunction

endpackage

// File: rtl/out_bcd_converter_bcd_digit_adj.sv
// Combinational "if >= 5 add 3" correction for a single BCD digit.
module bcd_digit_adj
    import out_bcd_converter_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = bcd_adjust(d);
    end

endmodule

// File: rtl/out_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
module out_bcd_converter
    import out_bcd_converter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] last;
    logic [BCD_W-1:0]      scratch;
    logic [BCD_W-1:0]      adj;
    logic                  trigger;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .d (scratch[4*g +: 4]),
                .q (adj[4*g +: 4])
            );
        end
    endgenerate

    always_comb begin
        trigger = start || (AUTO_START && (in != last));
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            last    <= '0;
            scratch <= '0;
            digits  <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        shreg   <= in;
                        last    <= in;
                        scratch <= '0;
                        cnt     <= CNT_W'(DATA_WIDTH);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Carry out of the top digit falls off the end of the scratch register.
                    scratch <= {adj[BCD_W-2:0], shreg[DATA_WIDTH-1]};
                    shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    digits <= scratch;
                    valid  <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
